// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
//   Shared definitions for the two-port memory arbiter:
//   - state_t : arbiter FSM state encoding
//   - port_t  : requester identifiers (CPU = 0, DISPLAY = 1)
//   - DEFAULT_ADDRESS_WIDTH / DEFAULT_DATA_WIDTH : default port widths
package memory_arbiter_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 16;
  localparam int DEFAULT_DATA_WIDTH    = 16;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    GRANT_CPU     = 3'd1,
    GRANT_DISPLAY = 3'd2,
    DONE_CPU      = 3'd3,
    DONE_DISPLAY  = 3'd4
  } state_t;

  typedef enum logic {
    CPU     = 1'b0,
    DISPLAY = 1'b1
  } port_t;

endpackage

// File: rtl/memory_arbiter_pick.sv
// memory_arbiter_pick
//   Combinational winner select for the two requesters.
//   Optional feature macro: MEMORY_ARBITER_ROUND_ROBIN_EN
//     defined   : on a tie the port that did not win last time is chosen
//                 (last_grant input present)
//     undefined : on a tie the CPU always wins (no last_grant input)
// Ports:
//   cpu_request, display_request : raw request lines
//   last_grant                   : most recent winner (round-robin build only)
//   grant_valid                  : at least one request is pending
//   grant_port                   : selected requester, meaningful when grant_valid
module memory_arbiter_pick
  import memory_arbiter_pkg::*;
(
  input  logic  cpu_request,
  input  logic  display_request,
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  input  port_t last_grant,
`endif
  output logic  grant_valid,
  output port_t grant_port
);

  always_comb begin
    grant_valid = cpu_request | display_request;
    grant_port  = CPU;
    if (cpu_request && display_request) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      // Alternate on contention: whoever was served last yields.
      if (last_grant == CPU) begin
        grant_port = DISPLAY;
      end else begin
        grant_port = CPU;
      end
`else
      grant_port = CPU;
`endif
    end else if (display_request) begin
      grant_port = DISPLAY;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Arbitrates a CPU port and a display/IO port onto one single-port memory
//   with a registered (1-cycle latency) read output. Each access takes three
//   cycles: IDLE (request sampled) -> GRANT_x (memory driven) -> DONE_x
//   (acknowledge pulse, read data valid) -> IDLE.
//   Requesters hold their request/address/data/write enable stable until
//   their acknowledge; nothing on the request side is registered here.
//   Optional feature macro: MEMORY_ARBITER_ROUND_ROBIN_EN (round-robin tie
//   break with a last_grant register; otherwise CPU wins ties).
// Ports:
//   clock, reset (synchronous, active-low)
//   cpu_request/_write_enable/_address/_write_data, cpu_acknowledge
//   display_request/_write_enable/_address/_write_data, display_acknowledge
//   memory_address, memory_write_data, memory_write_enable : memory drive
//   memory_read_data : memory registered read output
//   read_data        : read word, non-zero only while an acknowledge is high
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_request,
  input  logic                     cpu_write_enable,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0]    cpu_write_data,
  output logic                     cpu_acknowledge,
  input  logic                     display_request,
  input  logic                     display_write_enable,
  input  logic [ADDRESS_WIDTH-1:0] display_address,
  input  logic [DATA_WIDTH-1:0]    display_write_data,
  output logic                     display_acknowledge,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0]    memory_write_data,
  output logic                     memory_write_enable,
  input  logic [DATA_WIDTH-1:0]    memory_read_data,
  output logic [DATA_WIDTH-1:0]    read_data
);

  state_t state_reg;
  state_t state_next;
  logic   grant_valid;
  port_t  grant_port;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  port_t  last_grant_reg;
  port_t  last_grant_next;
`endif

  memory_arbiter_pick u_pick (
    .cpu_request     (cpu_request),
    .display_request (display_request),
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    .last_grant      (last_grant_reg),
`endif
    .grant_valid     (grant_valid),
    .grant_port      (grant_port)
  );

  // State register. Reset leaves any in-flight access behind without an
  // acknowledge; the requester is expected to ask again.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= IDLE;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last_grant_reg <= DISPLAY;
`endif
    end else begin
      state_reg      <= state_next;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last_grant_reg <= last_grant_next;
`endif
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, so a request that
  // disappears before then is simply never seen, and one still high during
  // DONE is picked up again by the following IDLE.
  always_comb begin
    state_next      = state_reg;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    last_grant_next = last_grant_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          last_grant_next = grant_port;
`endif
          if (grant_port == CPU) begin
            state_next = GRANT_CPU;
          end else begin
            state_next = GRANT_DISPLAY;
          end
        end
      end
      GRANT_CPU:     state_next = DONE_CPU;
      GRANT_DISPLAY: state_next = DONE_DISPLAY;
      DONE_CPU:      state_next = IDLE;
      DONE_DISPLAY:  state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  // Output decode. The memory bus is zero outside GRANT states so the idle
  // bus is quiet and easy to observe.
  always_comb begin
    memory_address      = '0;
    memory_write_data   = '0;
    memory_write_enable = 1'b0;
    cpu_acknowledge     = 1'b0;
    display_acknowledge = 1'b0;
    read_data           = '0;
    case (state_reg)
      GRANT_CPU: begin
        memory_address      = cpu_address;
        memory_write_data   = cpu_write_data;
        memory_write_enable = cpu_write_enable;
      end
      GRANT_DISPLAY: begin
        memory_address      = display_address;
        memory_write_data   = display_write_data;
        memory_write_enable = display_write_enable;
      end
      DONE_CPU: begin
        cpu_acknowledge = 1'b1;
        read_data       = memory_read_data;
      end
      DONE_DISPLAY: begin
        display_acknowledge = 1'b1;
        read_data           = memory_read_data;
      end
      default: begin
      end
    endcase
    // The state register only changes at the next edge, so a write in
    // progress must be blocked combinationally or it would commit on the
    // very edge that applies reset.
    if (!reset) begin
      memory_write_enable = 1'b0;
      cpu_acknowledge     = 1'b0;
      display_acknowledge = 1'b0;
      read_data           = '0;
    end
  end

endmodule
